stepper_pulse_gen: RTL
======================

# stepper_pulse_gen

Command-driven step/dir pulse generator for one stepper axis. It sits directly upstream of the `stepper0_step`/`stepper0_dir` IO pads and is fed by the Wishbone CSR bank of the motion core. It buffers move commands (direction, step count, step period) in a small FIFO. It emits step pulses with guaranteed pulse width and direction setup time, and tracks absolute position.

## Interface
Parameters:
- `STEP_W`, default 16: step high time in `sys_clk` cycles (≥1).
- `DIR_SETUP`, default 8: cycles from `dir` change to the next `step` rising edge (≥1).
- `FIFO_DEPTH`, default 4: command FIFO entries (power of two, ≥2).

Ports:
- `sys_clk`  in  1  single clock for the block.
- `sys_rst`  in  1  asynchronous, active-high reset.
- `cmd_valid`  in  1  command present.
- `cmd_ready`  out  1  FIFO can accept a command; equals !full.
- `cmd_dir`  in  1  1 = forward (position increments), 0 = reverse.
- `cmd_steps`  in  16  number of steps; 0 is legal.
- `cmd_period`  in  16  cycles between consecutive step rising edges.
- `abort`  in  1  synchronous stop request, single-cycle pulse.
- `step`  out  1  step pulse, registered.
- `dir`  out  1  direction, registered.
- `busy`  out  1  FSM not IDLE, or FIFO not empty.
- `fifo_level`  out  $clog2(FIFO_DEPTH)+1  number of queued commands.
- `position`  out  32  signed absolute step count, wraps modulo 2^32.

## Operation
- Reset values: `step`=0, `dir`=0, `busy`=0, `position`=0, `fifo_level`=0, `cmd_ready`=1. The FSM is in IDLE and the FIFO is empty.
- Push: a command is written when `cmd_valid && cmd_ready`. Pushes while full are not possible, because `cmd_ready`=0.
- Effective period: P = max(`cmd_period`, 2·STEP_W). The arithmetic is 17-bit unsigned and is latched at pop.
- FSM states: IDLE, SETUP, HIGH, LOW.
  - IDLE with FIFO non-empty: pop one command.
    - `cmd_steps`=0: discard the command. `dir` is unchanged. Stay IDLE and consider the next entry on the next cycle.
    - `cmd_dir`≠`dir`: update `dir` and enter SETUP.
    - Otherwise: enter HIGH.
  - SETUP: count DIR_SETUP cycles, then enter HIGH.
  - HIGH: `step`=1 for STEP_W cycles.
    - On entry to HIGH, `position` changes by +1 (`dir`=1) or −1 (`dir`=0).
    - Decrement the remaining step count, then enter LOW.
  - LOW: `step`=0 for P−STEP_W cycles. At the end of LOW:
    - If steps remain: enter HIGH.
    - Else, if the FIFO is non-empty: pop and apply the IDLE decision rules in the same cycle. This gives seamless back-to-back moves with no extra idle cycle.
    - Else: enter IDLE.
- Abort:
  - Sets a sticky abort flag. The FIFO is flushed immediately, so `fifo_level`=0 next cycle.
  - In SETUP or LOW: go to IDLE at once, with `step`=0.
  - In HIGH: complete the current STEP_W pulse, then go to IDLE. Pulse width is never truncated.
  - A push in the same cycle as abort is dropped.
- Simultaneous push and pop: `fifo_level` stays unchanged.

## Timing
- Idle-to-first-step latency, FIFO empty:
  - Command accepted at edge N; pop at N+1.
  - Same direction: `step` rises at N+2.
  - Direction change: `dir` toggles at N+2, and `step` rises at N+2+DIR_SETUP.
- Step rising edges within a command are exactly P cycles apart.
- Across back-to-back commands with the same direction:
  - The spacing is P_old, measured from the last rising edge of the old command to the first rising edge of the new one.
  - On a direction change, DIR_SETUP cycles are inserted before the first step of the new command.
- `dir` never changes while `step`=1, nor within DIR_SETUP cycles before a rising edge.
- `busy` drops the cycle after the final LOW phase ends with the FIFO empty.
- Reset asserted mid-pulse forces `step`=0 asynchronously. All state is lost.

## Test plan
- STEP_W=16, cmd {dir=1, steps=3, period=40}:
  - 3 pulses, each 16 cycles high, with rising edges 40 cycles apart.
  - `position` goes 0→3.
  - `busy` falls 24 cycles after the last fall of `step`.
- `cmd_period`=10 with STEP_W=16: the period is clamped to 32 cycles.
- Sequence {dir=1, steps=2} then {dir=0, steps=2}:
  - `dir` falls after the second LOW phase.
  - The next `step` rises exactly 8 cycles later.
  - `position` goes 0→2→0.
- Sequence {steps=0, dir=0} followed by {steps=1, dir=1}: the first command is dropped with no `dir` activity, and `position`=1.
- Push 5 commands with no gaps while the FSM is busy:
  - `cmd_ready` falls when `fifo_level`=4.
  - All 5 moves execute back-to-back with constant spacing.
- Abort 3 cycles into HIGH with 2 commands queued:
  - The pulse still lasts 16 cycles and `fifo_level`=0.
  - IDLE is reached after the pulse, with no further steps.
- Assert `sys_rst` mid-HIGH: `step`=0 and `position`=0 immediately.

Source files
------------

// File: rtl/stepper_pulse_gen.sv
// Step/dir pulse generator for one stepper axis: queued move commands, guaranteed
// pulse width and direction setup, absolute position tracking.
module stepper_pulse_gen #(
  parameter int STEP_W     = 16,
  parameter int DIR_SETUP  = 8,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          sys_clk,
  input  logic                          sys_rst,
  input  logic                          cmd_valid,
  output logic                          cmd_ready,
  input  logic                          cmd_dir,
  input  logic [15:0]                   cmd_steps,
  input  logic [15:0]                   cmd_period,
  input  logic                          abort,
  output logic                          step,
  output logic                          dir,
  output logic                          busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic [31:0]                   position
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [16:0] STEP_W_C  = 17'(STEP_W);
  localparam logic [16:0] P_MIN     = 17'(2 * STEP_W);
  localparam logic [16:0] SETUP_C   = 17'(DIR_SETUP);
  localparam logic [AW:0] DEPTH_C   = (AW+1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, SETUP, HIGH, LOW} state_t;

  logic [32:0]   mem_q [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [AW:0]   count_q;
  logic          push, do_pop;
  logic          head_dir;
  logic [15:0]   head_steps, head_period;
  logic [16:0]   head_per17, head_eff;

  state_t        state_q, state_d;
  logic [16:0]   timer_q, timer_d;
  logic [15:0]   rem_q, rem_d;
  logic [16:0]   period_q, period_d;
  logic          dir_q, dir_d;
  logic          abort_q, abort_d;
  logic          step_q, dir_out_q, busy_q;
  logic [31:0]   pos_q;

  assign cmd_ready = (count_q != DEPTH_C);
  assign push      = cmd_valid && cmd_ready && !abort;

  always_ff @(posedge sys_clk) begin
    if (push) mem_q[wr_ptr_q] <= {cmd_dir, cmd_steps, cmd_period};
  end

  // Abort flushes by rewinding both pointers; a same-cycle push is already masked.
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else if (abort) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push)   wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop) rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q <= count_q + (AW+1)'(push) - (AW+1)'(do_pop);
    end
  end

  assign {head_dir, head_steps, head_period} = mem_q[rd_ptr_q];
  assign head_per17 = {1'b0, head_period};
  assign head_eff   = (head_per17 > P_MIN) ? head_per17 : P_MIN;

  always_comb begin
    state_d  = state_q;
    timer_d  = timer_q;
    rem_d    = rem_q;
    period_d = period_q;
    dir_d    = dir_q;
    abort_d  = abort_q | abort;
    do_pop   = 1'b0;
    unique case (state_q)
      IDLE: do_pop = !abort && (count_q != '0);
      SETUP: begin
        if (abort) state_d = IDLE;
        else if (timer_q == '0) begin
          state_d = HIGH;
          timer_d = STEP_W_C - 17'd1;
        end else timer_d = timer_q - 17'd1;
      end
      HIGH: begin
        if (timer_q == '0) begin
          rem_d = rem_q - 16'd1;
          if (abort_q || abort) state_d = IDLE;
          else begin
            state_d = LOW;
            timer_d = period_q - STEP_W_C - 17'd1;
          end
        end else timer_d = timer_q - 17'd1;
      end
      LOW: begin
        if (abort) state_d = IDLE;
        else if (timer_q == '0) begin
          if (rem_q != '0) begin
            state_d = HIGH;
            timer_d = STEP_W_C - 17'd1;
          end else begin
            state_d = IDLE;
            do_pop  = (count_q != '0);
          end
        end else timer_d = timer_q - 17'd1;
      end
      default: state_d = IDLE;
    endcase
    // A pop decides the next move in the same cycle, so back-to-back moves lose no time.
    if (do_pop && (head_steps != '0)) begin
      rem_d    = head_steps;
      period_d = head_eff;
      if (head_dir != dir_q) begin
        dir_d   = head_dir;
        state_d = SETUP;
        timer_d = SETUP_C - 17'd1;
      end else begin
        state_d = HIGH;
        timer_d = STEP_W_C - 17'd1;
      end
    end
    if (state_d == IDLE) abort_d = 1'b0;
  end

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      state_q   <= IDLE;
      timer_q   <= '0;
      rem_q     <= '0;
      period_q  <= '0;
      dir_q     <= 1'b0;
      abort_q   <= 1'b0;
      step_q    <= 1'b0;
      dir_out_q <= 1'b0;
      busy_q    <= 1'b0;
      pos_q     <= '0;
    end else begin
      state_q   <= state_d;
      timer_q   <= timer_d;
      rem_q     <= rem_d;
      period_q  <= period_d;
      dir_q     <= dir_d;
      abort_q   <= abort_d;
      // Pad-side outputs trail the FSM by one cycle; position moves with the step edge.
      step_q    <= (state_q == HIGH);
      dir_out_q <= dir_q;
      busy_q    <= (state_q != IDLE) || (count_q != '0);
      if ((state_q == HIGH) && !step_q)
        pos_q <= pos_q + (dir_q ? 32'd1 : 32'hFFFF_FFFF);
    end
  end

  assign step       = step_q;
  assign dir        = dir_out_q;
  assign busy       = busy_q;
  assign fifo_level = count_q;
  assign position   = pos_q;

endmodule
